instr_sequencer: RTL
====================

# instr_sequencer

Multi-cycle instruction sequencer that drives the `Processor` datapath/control block. It owns the program counter and fetches instructions from instruction memory over a req/ack handshake. It presents the latched instruction to `Processor`, sequences the execute, memory and writeback phases from the decoded control flags, and resolves B/CBZ branches. It sits between the instruction/data memory ports and `Processor`, and is the top-level controller of the CPU.

## Interface
- `PC_WIDTH`, 32, program counter and instruction address width
- `RESET_PC`, 0, PC value loaded on reset
- `clock` in 1: system clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `run` in 1: level enable; sequencing starts and continues while high
- `imemAddr` out PC_WIDTH: fetch address, equal to `pc` while in FETCH
- `imemReq` out 1: fetch request
- `imemAck` in 1: fetch complete; `imemData` is valid this cycle
- `imemData` in 32: fetched instruction word
- `instruction` out 32: latched instruction driven into `Processor`
- `branchFlag`, `unconditionalBranchFlag`, `memReadFlag`, `memWriteFlag`, `regWriteFlag` in 1 each: decoded control from `Processor`
- `zeroFlag` in 1: ALU zero result
- `dmemReq` out 1: data memory access request
- `dmemAck` in 1: data access complete
- `regWriteEnable` out 1: one-cycle register-file write strobe
- `pc` out PC_WIDTH: current program counter
- `retired` out 1: one-cycle pulse per completed instruction
- `retireCount` out 32: count of retired instructions; wraps
- `halted` out 1: high in HALT
- `state` out 3: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6

## Operation
- Reset (async, `reset_n`=0) sets: state=IDLE, `pc`=RESET_PC, `instruction`=0, `retireCount`=0. All strobes/requests (`imemReq`, `dmemReq`, `regWriteEnable`, `retired`, `halted`) are 0.
- IDLE: `run`=1 -> FETCH.
- FETCH: `imemReq`=1, `imemAddr`=`pc`, both held stable until `imemAck`. On `imemAck`: latch `imemData` into `instruction` -> DECODE. `imemAck` is ignored outside FETCH.
- DECODE: one cycle for `Processor` control to settle -> EXECUTE.
- EXECUTE: one cycle.
  - Register taken = `unconditionalBranchFlag` | (`branchFlag` & `zeroFlag`).
  - Register the target offset: B uses imm26 = `instruction[25:0]`; CBZ uses imm19 = `instruction[23:5]`. Sign-extend, then shift left 2.
  - `memReadFlag`|`memWriteFlag` -> MEMORY, else -> WRITEBACK.
- MEMORY: `dmemReq`=1 until `dmemAck` -> WRITEBACK. `dmemAck` is ignored outside MEMORY.
- WRITEBACK, one cycle:
  - `regWriteEnable`=`regWriteFlag`, `retired`=1, `retireCount`+1.
  - `pc` <= taken ? `pc`+offset : `pc`+4, modulo 2^PC_WIDTH.
  - Taken with offset 0 (branch-to-self) -> HALT, `pc` unchanged.
  - Otherwise `run` ? FETCH : IDLE.
- HALT: `halted`=1, no requests issued; exits only on reset.
- Control-flag inputs are sampled only in EXECUTE and WRITEBACK.

## Timing
- Minimum latency with same-cycle acks: 4 cycles per ALU/branch instruction, 5 per load/store.
- `imemReq` rises on the first FETCH cycle. An ack in that same cycle completes the fetch.
- Deasserting `run` mid-instruction lets the instruction complete; the sequencer parks in IDLE after WRITEBACK.
- Reset mid-operation drops `imemReq`/`dmemReq` immediately (combinational from state) and aborts the instruction with no retire.
- Simultaneous `imemAck` and `run` falling in FETCH: the fetch completes normally.
- PC and branch target wrap silently; a negative offset below 0 wraps.

## Test plan
- Reset: hold `reset_n`=0 mid-FETCH -> `imemReq`=0 immediately; `pc`=0, state=0, `instruction`=0, `retireCount`=0.
- ADD 32'h8B150289, `run`=1, `imemAck` same cycle, `regWriteFlag`=1 -> `regWriteEnable` and `retired` pulse on 4th cycle; `pc`=4; `retireCount`=1.
- LDUR 32'hF84F0149, `memReadFlag`=1, `dmemAck` after 3 cycles -> `dmemReq` high exactly 3 cycles, then WRITEBACK; `pc`=4.
- CBZ 32'hB4000040 at `pc`=8: `zeroFlag`=1 -> `pc`=16; repeat with `zeroFlag`=0 -> `pc`=12.
- B 32'h14000000 (branch-to-self), `unconditionalBranchFlag`=1 -> state=6, `halted`=1, `pc` unchanged; `imemReq` stays 0 for 20 cycles.
- Fetch wait: `imemAck` delayed 5 cycles -> `imemReq` and `imemAddr` stable throughout; `instruction` updates only on the ack cycle.

Source files
------------

// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// instr_sequencer: multi-cycle fetch/decode/execute/memory/writeback controller.
// Owns the PC, fetches over a req/ack handshake, resolves B/CBZ branches and
// counts retired instructions. A taken branch-to-self parks the core in HALT.
module instr_sequencer #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    output logic [PC_WIDTH-1:0] imemAddr,
    output logic                imemReq,
    input  logic                imemAck,
    input  logic [31:0]         imemData,
    output logic [31:0]         instruction,
    input  logic                branchFlag,
    input  logic                unconditionalBranchFlag,
    input  logic                memReadFlag,
    input  logic                memWriteFlag,
    input  logic                regWriteFlag,
    input  logic                zeroFlag,
    output logic                dmemReq,
    input  logic                dmemAck,
    output logic                regWriteEnable,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retired,
    output logic [31:0]         retireCount,
    output logic                halted,
    output logic [2:0]          state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         retire_cnt_q, retire_cnt_d;
    logic                taken_q, taken_d;
    logic [PC_WIDTH-1:0] offset_q, offset_d;

    // Byte offsets: sign-extended word immediates scaled by 4 (PC_WIDTH >= 29 assumed)
    logic [PC_WIDTH-1:0] off_b, off_cbz;
    assign off_b   = {{(PC_WIDTH-28){instr_q[25]}}, instr_q[25:0], 2'b00};
    assign off_cbz = {{(PC_WIDTH-21){instr_q[23]}}, instr_q[23:5], 2'b00};

    // Next-state and datapath register updates for each sequencing phase
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        retire_cnt_d = retire_cnt_q;
        taken_d      = taken_q;
        offset_d     = offset_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imemAck) begin
                    instr_d = imemData;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                taken_d  = unconditionalBranchFlag | (branchFlag & zeroFlag);
                offset_d = unconditionalBranchFlag ? off_b : off_cbz;
                state_d  = (memReadFlag | memWriteFlag) ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (dmemAck) state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                retire_cnt_d = retire_cnt_q + 32'd1;
                if (taken_q && (offset_q == '0)) begin
                    // Branch-to-self is the program's stop marker
                    state_d = ST_HALT;
                end else begin
                    pc_d    = taken_q ? (pc_q + offset_q) : (pc_q + PC_WIDTH'(4));
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            retire_cnt_q <= '0;
            taken_q      <= 1'b0;
            offset_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retire_cnt_q <= retire_cnt_d;
            taken_q      <= taken_d;
            offset_q     <= offset_d;
        end
    end

    // Requests and strobes decode straight from state so reset drops them at once
    always_comb begin
        imemReq        = (state_q == ST_FETCH);
        dmemReq        = (state_q == ST_MEMORY);
        retired        = (state_q == ST_WRITEBACK);
        regWriteEnable = (state_q == ST_WRITEBACK) & regWriteFlag;
        halted         = (state_q == ST_HALT);
        imemAddr       = pc_q;
        pc             = pc_q;
        instruction    = instr_q;
        retireCount    = retire_cnt_q;
        state          = state_q;
    end

endmodule
